// File: rtl/ipsxb_cmd_parser_32bit.sv
// rtl/ipsxb_cmd_parser_32bit.sv - UART byte-frame command parser driving a 32-bit register block
// Parses HDR/ADDR[/DATA3..0] frames, issues one command, returns write ack or read bytes.
module ipsxb_cmd_parser_32bit #(
   parameter logic [23:0] BYTE_TIMEOUT = 24'd500000,
   parameter logic [23:0] DONE_TIMEOUT = 24'd1000000,
   parameter logic        WR_ACK_EN    = 1'b1,
   parameter logic [7:0]  WR_ACK       = 8'h4B,
   parameter logic [7:0]  ERR_CODE     = 8'hEE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [8:0]  addr,
   output logic [31:0] data,
   output logic        we,
   output logic        cmd_en,
   input  logic        cmd_done,
   input  logic [31:0] fifo_data,
   output logic        fifo_data_valid,
   input  logic        fifo_data_req,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [2:0] {S_HDR, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_TX} state_t;

   state_t      state_q;
   logic [23:0] timer_q, timer_d;
   logic [8:0]  addr_q;
   logic [31:0] data_q, cap_q, tx_buf_q, rd_word;
   logic        we_q, cmd_en_q, frame_err_q, cap_full_q, tx_valid_q, tx_rd_q, cap_hit;
   logic [1:0]  byte_cnt_q;
   logic [2:0]  tx_left_q;

   // One timer serves both the inter-byte and the cmd_done timeouts; it saturates.
   assign timer_d = (timer_q == 24'hFFFFFF) ? timer_q : timer_q + 24'd1;
   assign cap_hit = fifo_data_req & ~cap_full_q;
   // A capture in the same cycle as cmd_done bypasses straight into the response.
   assign rd_word = cap_full_q ? cap_q : (cap_hit ? fifo_data : {4{ERR_CODE}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HDR;
         timer_q     <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         cap_q       <= '0;
         tx_buf_q    <= '0;
         we_q        <= 1'b0;
         cmd_en_q    <= 1'b0;
         frame_err_q <= 1'b0;
         cap_full_q  <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_rd_q     <= 1'b0;
         byte_cnt_q  <= '0;
         tx_left_q   <= '0;
      end else begin
         cmd_en_q    <= 1'b0;
         frame_err_q <= 1'b0;
         if (cap_hit) begin
            cap_q      <= fifo_data;
            cap_full_q <= 1'b1;
         end
         case (state_q)
            S_HDR: if (rx_valid) begin
               if (rx_data[7:4] == 4'hA) begin
                  we_q      <= rx_data[3];
                  addr_q[8] <= rx_data[0];
                  timer_q   <= '0;
                  state_q   <= S_ADDR;
               end else begin
                  frame_err_q <= 1'b1;
               end
            end
            S_ADDR: if (rx_valid) begin
               addr_q[7:0] <= rx_data;
               timer_q     <= '0;
               byte_cnt_q  <= '0;
               state_q     <= we_q ? S_DATA : S_ISSUE;
            end else if (timer_q >= BYTE_TIMEOUT) begin
               frame_err_q <= 1'b1;
               state_q     <= S_HDR;
            end else begin
               timer_q <= timer_d;
            end
            S_DATA: if (rx_valid) begin
               data_q     <= {data_q[23:0], rx_data};
               byte_cnt_q <= byte_cnt_q + 2'd1;
               timer_q    <= '0;
               if (byte_cnt_q == 2'd3) state_q <= S_ISSUE;
            end else if (timer_q >= BYTE_TIMEOUT) begin
               frame_err_q <= 1'b1;
               state_q     <= S_HDR;
            end else begin
               timer_q <= timer_d;
            end
            S_ISSUE: begin
               frame_err_q <= rx_valid;
               cmd_en_q    <= 1'b1;
               timer_q     <= '0;
               cap_full_q  <= 1'b0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               frame_err_q <= rx_valid;
               if (cmd_done) begin
                  if (we_q) begin
                     if (WR_ACK_EN) begin
                        tx_buf_q   <= {WR_ACK, 24'h0};
                        tx_left_q  <= 3'd1;
                        tx_rd_q    <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                     end else begin
                        state_q <= S_HDR;
                     end
                  end else begin
                     tx_buf_q   <= rd_word;
                     tx_left_q  <= 3'd4;
                     tx_rd_q    <= 1'b1;
                     tx_valid_q <= 1'b1;
                     state_q    <= S_TX;
                  end
               end else if (timer_q >= DONE_TIMEOUT) begin
                  tx_buf_q   <= {ERR_CODE, 24'h0};
                  tx_left_q  <= 3'd1;
                  tx_rd_q    <= 1'b0;
                  tx_valid_q <= 1'b1;
                  state_q    <= S_TX;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_TX: begin
               frame_err_q <= rx_valid;
               if (tx_valid_q && tx_ready) begin
                  tx_buf_q  <= {tx_buf_q[23:0], 8'h00};
                  tx_left_q <= tx_left_q - 3'd1;
                  if (tx_left_q == 3'd1) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= S_HDR;
                     if (tx_rd_q) cap_full_q <= 1'b0;
                  end
               end
            end
            default: state_q <= S_HDR;
         endcase
      end
   end

   assign tx_data         = tx_buf_q[31:24];
   assign tx_valid        = tx_valid_q;
   assign addr            = addr_q;
   assign data            = data_q;
   assign we              = we_q;
   assign cmd_en          = cmd_en_q;
   assign frame_err       = frame_err_q;
   assign fifo_data_valid = ~cap_full_q;
   assign busy            = (state_q != S_HDR);

endmodule

// File: tb/tb_ipsxb_cmd_parser_32bit.sv
// tb/tb_ipsxb_cmd_parser_32bit.sv - directed vector bench for ipsxb_cmd_parser_32bit
module tb_ipsxb_cmd_parser_32bit;

   localparam logic [23:0] BT = 24'd40;
   localparam logic [23:0] DT = 24'd60;

   logic        clk = 1'b0;
   logic        rst_n, rx_valid, tx_valid, tx_ready, we, cmd_en, cmd_done;
   logic        fifo_data_valid, fifo_data_req, frame_err, busy;
   logic [7:0]  rx_data, tx_data;
   logic [8:0]  addr;
   logic [31:0] data, fifo_data;

   ipsxb_cmd_parser_32bit #(.BYTE_TIMEOUT(BT), .DONE_TIMEOUT(DT), .WR_ACK_EN(1'b1),
                            .WR_ACK(8'h4B), .ERR_CODE(8'hEE)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .addr(addr), .data(data), .we(we), .cmd_en(cmd_en), .cmd_done(cmd_done),
      .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid), .fifo_data_req(fifo_data_req),
      .frame_err(frame_err), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  hdr;
      logic [7:0]  alo;
      logic [31:0] wdata;
      logic [31:0] fword;
      int          req_mode;   // 0 no capture, 1 req with cmd_done, 2 req before cmd_done
      logic [8:0]  eaddr;
      logic        ewe;
      int          enb;
      logic [31:0] ebytes;
   } vec_t;

   vec_t vt[5];
   int errors = 0, checks = 0;
   int cmd_cnt = 0, ferr_cnt = 0;
   logic [8:0]  cap_addr;
   logic [31:0] cap_data;
   logic        cap_we;
   logic [7:0]  txq[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_en) begin
            cmd_cnt  <= cmd_cnt + 1;
            cap_addr <= addr;
            cap_data <= data;
            cap_we   <= we;
         end
         if (frame_err) ferr_cnt <= ferr_cnt + 1;
         if (tx_valid && tx_ready) txq.push_back(tx_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
      chk({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
      chk({tag, "_addr"}, {23'h0, addr}, 32'h0);
      chk({tag, "_data"}, data, 32'h0);
      chk({tag, "_we"}, {31'h0, we}, 32'h0);
      chk({tag, "_cmd_en"}, {31'h0, cmd_en}, 32'h0);
      chk({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_fifo_data_valid"}, {31'h0, fifo_data_valid}, 32'h1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
   endtask

   task automatic wait_cmd(input int c0);
      int b = 0;
      while (cmd_cnt == c0 && b < 50) begin tick(); b++; end
      chk("cmd_en_count", cmd_cnt - c0, 1);
   endtask

   task automatic run_txn(input vec_t v, input int stall);
      int c0, f0, b;
      logic [7:0]  first;
      logic        ok;
      logic [31:0] got;
      txq.delete();
      c0 = cmd_cnt;
      f0 = ferr_cnt;
      send_byte(v.hdr);
      send_byte(v.alo);
      if (v.ewe) for (int k = 3; k >= 0; k--) send_byte(v.wdata[8*k +: 8]);
      wait_cmd(c0);
      chk("cmd_addr", {23'h0, cap_addr}, {23'h0, v.eaddr});
      chk("cmd_we", {31'h0, cap_we}, {31'h0, v.ewe});
      if (v.ewe) chk("cmd_wdata", cap_data, v.wdata);
      if (stall > 0) tx_ready = 1'b0;
      repeat (4) tick();
      chk("addr_hold", {23'h0, addr}, {23'h0, v.eaddr});
      fifo_data = v.fword;
      if (v.req_mode == 2) begin
         fifo_data_req = 1'b1;
         tick();
         fifo_data_req = 1'b0;
         chk("fifo_valid_after_cap", {31'h0, fifo_data_valid}, 32'h0);
         tick();
      end
      fifo_data_req = (v.req_mode == 1);
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      fifo_data_req = 1'b0;
      if (stall == 0) begin
         b = 0;
         while (txq.size() < v.enb && b < 200) begin tick(); b++; end
      end else begin
         for (int k = 0; k < v.enb; k++) begin
            b = 0;
            while (!tx_valid && b < 100) begin tick(); b++; end
            first = tx_data;
            ok = 1'b1;
            repeat (stall) begin
               tick();
               if (!(tx_valid && tx_data == first)) ok = 1'b0;
            end
            chk("tx_hold", {31'h0, ok}, 32'h1);
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
         end
      end
      chk("tx_valid_after_last", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b1;
      tick();
      got = '0;
      foreach (txq[i]) got = {got[23:0], txq[i]};
      chk("tx_count", txq.size(), v.enb);
      chk("tx_bytes", got, v.ebytes);
      chk("fifo_rearmed", {31'h0, fifo_data_valid}, 32'h1);
      chk("busy_idle", {31'h0, busy}, 32'h0);
      chk("no_frame_err", ferr_cnt - f0, 0);
   endtask

   initial begin
      int c0, f0, b;
      vt[0] = '{8'hA8, 8'h03, 32'h12345678, 32'h0,        0, 9'h003, 1'b1, 1, 32'h0000004B};
      vt[1] = '{8'hA1, 8'hFF, 32'h0,        32'h20200729, 1, 9'h1FF, 1'b0, 4, 32'h20200729};
      vt[2] = '{8'hA0, 8'h10, 32'h0,        32'hDEADBEEF, 2, 9'h010, 1'b0, 4, 32'hDEADBEEF};
      vt[3] = '{8'hA6, 8'h55, 32'h0,        32'h0,        0, 9'h055, 1'b0, 4, 32'hEEEEEEEE};
      vt[4] = '{8'hAF, 8'h80, 32'hA55A00FF, 32'h0,        0, 9'h180, 1'b1, 1, 32'h0000004B};

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
      cmd_done = 1'b0; fifo_data = '0; fifo_data_req = 1'b0;
      repeat (3) tick();
      chk_reset("rst");
      rst_n = 1'b1;
      tick();
      chk_reset("idle");

      for (int i = 0; i < 5; i++) run_txn(vt[i], 0);

      // bad header
      f0 = ferr_cnt; c0 = cmd_cnt;
      send_byte(8'h5A);
      chk("badhdr_frame_err", ferr_cnt - f0, 1);
      chk("badhdr_busy", {31'h0, busy}, 32'h0);

      // inter-byte timeout mid write frame
      f0 = ferr_cnt;
      send_byte(8'hA8); send_byte(8'h03); send_byte(8'h12);
      chk("bto_busy_before", {31'h0, busy}, 32'h1);
      repeat (int'(BT) + 20) tick();
      chk("bto_frame_err", ferr_cnt - f0, 1);
      chk("bto_no_cmd", cmd_cnt - c0, 0);
      chk("bto_busy", {31'h0, busy}, 32'h0);

      // cmd_done timeout, then late req/done
      txq.delete();
      c0 = cmd_cnt;
      send_byte(8'hA8); send_byte(8'h07);
      for (int k = 3; k >= 0; k--) send_byte(8'hC0 + 8'(k));
      wait_cmd(c0);
      b = 0;
      while (txq.size() < 1 && b < int'(DT) + 50) begin tick(); b++; end
      chk("dto_count", txq.size(), 1);
      chk("dto_byte", (txq.size() > 0) ? {24'h0, txq[0]} : 32'hFFFFFFFF, 32'h000000EE);
      tick();
      fifo_data = 32'h11223344; fifo_data_req = 1'b1;
      tick();
      fifo_data_req = 1'b0;
      chk("late_cap", {31'h0, fifo_data_valid}, 32'h0);
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      repeat (3) tick();
      chk("late_done_busy", {31'h0, busy}, 32'h0);
      chk("late_done_no_tx", txq.size(), 1);
      run_txn(vt[3], 0);
      run_txn(vt[0], 0);

      // read with tx backpressure
      run_txn(vt[1], 10);

      // reset mid S_DATA
      send_byte(8'hA8); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
      chk("pre_rst_busy", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset("rst_data");
      tick();
      rst_n = 1'b1;
      tick();
      run_txn(vt[0], 0);

      // reset mid S_TX
      txq.delete();
      c0 = cmd_cnt;
      send_byte(8'hA1); send_byte(8'hFF);
      wait_cmd(c0);
      tx_ready = 1'b0;
      repeat (2) tick();
      fifo_data = 32'h20200729; fifo_data_req = 1'b1; cmd_done = 1'b1;
      tick();
      fifo_data_req = 1'b0; cmd_done = 1'b0;
      tick();
      chk("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset("rst_tx");
      tick();
      rst_n = 1'b1;
      tx_ready = 1'b1;
      tick();
      chk("rst_tx_no_bytes", txq.size(), 0);
      run_txn(vt[1], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
